// File: rtl/ibex_arb_pkg.sv
// Shared types and constants for the Ibex instruction/data memory arbiter.
package ibex_arb_pkg;

   typedef enum logic {
      ARB_INSTR = 1'b0,
      ARB_DATA  = 1'b1
   } arb_id_e;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   // Byte enable driven downstream for every instruction fetch.
   localparam logic [3:0] INSTR_BE = 4'hF;

endpackage

// File: rtl/ibex_arb_id_fifo.sv
// In-order FIFO of requester IDs for transactions granted but not yet answered.
module ibex_arb_id_fifo
   import ibex_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  arb_id_e          push_id,
   input  logic             pop,
   output arb_id_e          head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   arb_id_e          entries [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage holds only IDs, so it needs no reset; occupancy is tracked by count.
   always_ff @(posedge clock) begin
      if (push) begin
         entries[wr_ptr] <= push_id;
      end
   end

   // Pointers and occupancy; push and pop in one cycle leave the count unchanged.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = entries[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Two-to-one arbiter between the Ibex fetch and load/store ports onto one memory bus.
// Build option: define IBEX_ARB_ROUND_ROBIN_EN for round-robin selection;
// otherwise data requests always win over instruction requests.
module ibex_mem_arbiter
   import ibex_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned CNT_W           = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_instr_req_i,
   input  logic [31:0]      io_instr_addr_i,
   output logic             io_instr_gnt_o,
   output logic             io_instr_rvalid_o,
   output logic [31:0]      io_instr_rdata_o,
   output logic             io_instr_err_o,
   input  logic             io_data_req_i,
   input  logic             io_data_we_i,
   input  logic [3:0]       io_data_be_i,
   input  logic [31:0]      io_data_addr_i,
   input  logic [31:0]      io_data_wdata_i,
   output logic             io_data_gnt_o,
   output logic             io_data_rvalid_o,
   output logic [31:0]      io_data_rdata_o,
   output logic             io_data_err_o,
   output logic             io_mem_req_o,
   output logic             io_mem_we_o,
   output logic [3:0]       io_mem_be_o,
   output logic [31:0]      io_mem_addr_o,
   output logic [31:0]      io_mem_wdata_o,
   input  logic             io_mem_gnt_i,
   input  logic             io_mem_rvalid_i,
   input  logic [31:0]      io_mem_rdata_i,
   input  logic             io_mem_err_i,
   output logic [CNT_W-1:0] io_outstanding_o,
   output logic             io_protocol_err_o
);

   arb_state_e state_q, state_d;
   arb_id_e    held_q, held_d;
   arb_id_e    sel_id;
   arb_id_e    head_id;
   logic       favour_data;
   logic       mem_req;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic       proto_err_q;

`ifdef IBEX_ARB_ROUND_ROBIN_EN
   arb_id_e last_q;

   // Remember who was granted last so a contested cycle goes to the other side.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= ARB_INSTR;
      end else if (fifo_push) begin
         last_q <= sel_id;
      end
   end

   assign favour_data = (last_q == ARB_INSTR);
`else
   assign favour_data = 1'b1;
`endif

   // Choose the requester: a held selection is frozen until its grant.
   always_comb begin
      sel_id = ARB_INSTR;
      if (state_q == ARB_HOLD) begin
         sel_id = held_q;
      end else if (io_data_req_i && (favour_data || !io_instr_req_i)) begin
         sel_id = ARB_DATA;
      end
   end

   assign mem_req   = ((state_q == ARB_HOLD) || io_instr_req_i || io_data_req_i) && !fifo_full;
   assign fifo_push = mem_req && io_mem_gnt_i;
   assign fifo_pop  = io_mem_rvalid_i && !fifo_empty;

   ibex_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_id_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (fifo_push),
      .push_id (sel_id),
      .pop     (fifo_pop),
      .head    (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (io_outstanding_o)
   );

   // FSM state and held selection registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         held_q  <= ARB_INSTR;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   // Enter HOLD when a presented request is not granted; leave on grant.
   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      case (state_q)
         ARB_IDLE: begin
            if (mem_req && !io_mem_gnt_i) begin
               state_d = ARB_HOLD;
               held_d  = sel_id;
            end
         end
         ARB_HOLD: begin
            if (io_mem_gnt_i) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Drive the downstream request, upstream grants and steered responses.
   always_comb begin
      io_mem_req_o   = mem_req;
      io_mem_we_o    = 1'b0;
      io_mem_be_o    = '0;
      io_mem_addr_o  = '0;
      io_mem_wdata_o = '0;
      if (mem_req) begin
         if (sel_id == ARB_DATA) begin
            io_mem_we_o    = io_data_we_i;
            io_mem_be_o    = io_data_be_i;
            io_mem_addr_o  = io_data_addr_i;
            io_mem_wdata_o = io_data_wdata_i;
         end else begin
            io_mem_be_o    = INSTR_BE;
            io_mem_addr_o  = io_instr_addr_i;
         end
      end
      io_instr_gnt_o    = fifo_push && (sel_id == ARB_INSTR);
      io_data_gnt_o     = fifo_push && (sel_id == ARB_DATA);
      io_instr_rvalid_o = fifo_pop && (head_id == ARB_INSTR);
      io_data_rvalid_o  = fifo_pop && (head_id == ARB_DATA);
      io_instr_rdata_o  = io_instr_rvalid_o ? io_mem_rdata_i : '0;
      io_data_rdata_o   = io_data_rvalid_o ? io_mem_rdata_i : '0;
      io_instr_err_o    = io_instr_rvalid_o && io_mem_err_i;
      io_data_err_o     = io_data_rvalid_o && io_mem_err_i;
   end

   // A response with nothing outstanding is dropped and flagged until reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         proto_err_q <= 1'b0;
      end else if (io_mem_rvalid_i && fifo_empty) begin
         proto_err_q <= 1'b1;
      end
   end

   assign io_protocol_err_o = proto_err_q;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter (directed scenarios plus randomized traffic).
module tb_ibex_mem_arbiter;

   localparam int MAXO = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        io_instr_req_i, io_data_req_i, io_data_we_i;
   logic [31:0] io_instr_addr_i, io_data_addr_i, io_data_wdata_i;
   logic [3:0]  io_data_be_i;
   logic        io_instr_gnt_o, io_instr_rvalid_o, io_instr_err_o;
   logic [31:0] io_instr_rdata_o;
   logic        io_data_gnt_o, io_data_rvalid_o, io_data_err_o;
   logic [31:0] io_data_rdata_o;
   logic        io_mem_req_o, io_mem_we_o;
   logic [3:0]  io_mem_be_o;
   logic [31:0] io_mem_addr_o, io_mem_wdata_o;
   logic        io_mem_gnt_i, io_mem_rvalid_i, io_mem_err_i;
   logic [31:0] io_mem_rdata_i;
   logic [2:0]  io_outstanding_o;
   logic        io_protocol_err_o;

   int total = 0;
   int bad   = 0;

   ibex_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
      .clock(clock), .reset(reset),
      .io_instr_req_i(io_instr_req_i), .io_instr_addr_i(io_instr_addr_i),
      .io_instr_gnt_o(io_instr_gnt_o), .io_instr_rvalid_o(io_instr_rvalid_o),
      .io_instr_rdata_o(io_instr_rdata_o), .io_instr_err_o(io_instr_err_o),
      .io_data_req_i(io_data_req_i), .io_data_we_i(io_data_we_i), .io_data_be_i(io_data_be_i),
      .io_data_addr_i(io_data_addr_i), .io_data_wdata_i(io_data_wdata_i),
      .io_data_gnt_o(io_data_gnt_o), .io_data_rvalid_o(io_data_rvalid_o),
      .io_data_rdata_o(io_data_rdata_o), .io_data_err_o(io_data_err_o),
      .io_mem_req_o(io_mem_req_o), .io_mem_we_o(io_mem_we_o), .io_mem_be_o(io_mem_be_o),
      .io_mem_addr_o(io_mem_addr_o), .io_mem_wdata_o(io_mem_wdata_o),
      .io_mem_gnt_i(io_mem_gnt_i), .io_mem_rvalid_i(io_mem_rvalid_i),
      .io_mem_rdata_i(io_mem_rdata_i), .io_mem_err_i(io_mem_err_i),
      .io_outstanding_o(io_outstanding_o), .io_protocol_err_o(io_protocol_err_o)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      io_instr_req_i = 1'b0; io_instr_addr_i = '0;
      io_data_req_i = 1'b0; io_data_we_i = 1'b0; io_data_be_i = '0;
      io_data_addr_i = '0; io_data_wdata_i = '0;
      io_mem_gnt_i = 1'b0; io_mem_rvalid_i = 1'b0; io_mem_rdata_i = '0; io_mem_err_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) begin
         clear_inputs();
         io_mem_rvalid_i = 1'b1;
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      total++; if (io_outstanding_o !== 3'd0) begin bad++; $display("FAIL reset.count got=%0d exp=0", io_outstanding_o); end
      total++; if (io_protocol_err_o !== 1'b0) begin bad++; $display("FAIL reset.proto_err got=%0b exp=0", io_protocol_err_o); end
      total++; if ({io_mem_req_o, io_instr_gnt_o, io_data_gnt_o, io_instr_rvalid_o, io_data_rvalid_o} !== 5'b0) begin
         bad++; $display("FAIL reset.ctrl got=%05b exp=00000", {io_mem_req_o, io_instr_gnt_o, io_data_gnt_o, io_instr_rvalid_o, io_data_rvalid_o}); end
      total++; if ({io_mem_addr_o, io_mem_wdata_o, io_mem_be_o, io_mem_we_o} !== 69'd0) begin
         bad++; $display("FAIL reset.mem_data got addr=%0h be=%0h exp zeros", io_mem_addr_o, io_mem_be_o); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_instr_only();
      do_reset();
      io_instr_req_i = 1'b1; io_instr_addr_i = 32'h100; io_mem_gnt_i = 1'b1;
      settle();
      total++; if (io_instr_gnt_o !== 1'b1 || io_data_gnt_o !== 1'b0) begin bad++; $display("FAIL instr_only.gnt got i=%0b d=%0b exp i=1 d=0", io_instr_gnt_o, io_data_gnt_o); end
      total++; if (io_mem_addr_o !== 32'h100 || io_mem_we_o !== 1'b0 || io_mem_be_o !== 4'hF || io_mem_wdata_o !== 32'h0) begin
         bad++; $display("FAIL instr_only.mem got addr=%0h we=%0b be=%0h wd=%0h exp 100/0/f/0", io_mem_addr_o, io_mem_we_o, io_mem_be_o, io_mem_wdata_o); end
      tick();
      clear_inputs();
      io_mem_rvalid_i = 1'b1; io_mem_rdata_i = 32'hDEADBEEF;
      settle();
      total++; if (io_instr_rvalid_o !== 1'b1 || io_instr_rdata_o !== 32'hDEADBEEF || io_data_rvalid_o !== 1'b0) begin
         bad++; $display("FAIL instr_only.resp got rv=%0b rd=%0h drv=%0b exp 1/deadbeef/0", io_instr_rvalid_o, io_instr_rdata_o, io_data_rvalid_o); end
      total++; if (io_data_rdata_o !== 32'h0) begin bad++; $display("FAIL instr_only.data_rdata got=%0h exp=0", io_data_rdata_o); end
      tick();
      clear_inputs();
      settle();
      total++; if (io_outstanding_o !== 3'd0) begin bad++; $display("FAIL instr_only.count got=%0d exp=0", io_outstanding_o); end
   endtask

   task automatic test_priority();
      do_reset();
      io_instr_req_i = 1'b1; io_instr_addr_i = 32'h300;
      io_data_req_i = 1'b1; io_data_addr_i = 32'h200; io_data_we_i = 1'b1; io_data_be_i = 4'h3; io_data_wdata_i = 32'h55;
      io_mem_gnt_i = 1'b1;
      settle();
      total++; if (io_data_gnt_o !== 1'b1 || io_instr_gnt_o !== 1'b0) begin bad++; $display("FAIL prio.first got d=%0b i=%0b exp d=1 i=0", io_data_gnt_o, io_instr_gnt_o); end
      total++; if (io_mem_addr_o !== 32'h200 || io_mem_we_o !== 1'b1 || io_mem_be_o !== 4'h3 || io_mem_wdata_o !== 32'h55) begin
         bad++; $display("FAIL prio.data_fields got addr=%0h we=%0b be=%0h wd=%0h exp 200/1/3/55", io_mem_addr_o, io_mem_we_o, io_mem_be_o, io_mem_wdata_o); end
      tick();
      io_data_req_i = 1'b0;
      settle();
      total++; if (io_instr_gnt_o !== 1'b1 || io_mem_addr_o !== 32'h300) begin bad++; $display("FAIL prio.second got i=%0b addr=%0h exp 1/300", io_instr_gnt_o, io_mem_addr_o); end
      tick();
      clear_inputs();
      io_mem_rvalid_i = 1'b1; io_mem_rdata_i = 32'hA;
      settle();
      total++; if (io_outstanding_o !== 3'd2) begin bad++; $display("FAIL prio.count got=%0d exp=2", io_outstanding_o); end
      total++; if (io_data_rvalid_o !== 1'b1 || io_data_rdata_o !== 32'hA || io_instr_rvalid_o !== 1'b0) begin
         bad++; $display("FAIL prio.resp_d got drv=%0b rd=%0h irv=%0b exp 1/a/0", io_data_rvalid_o, io_data_rdata_o, io_instr_rvalid_o); end
      tick();
      io_mem_rdata_i = 32'hB; io_mem_err_i = 1'b1;
      settle();
      total++; if (io_instr_rvalid_o !== 1'b1 || io_instr_rdata_o !== 32'hB || io_instr_err_o !== 1'b1 || io_data_rvalid_o !== 1'b0 || io_data_err_o !== 1'b0) begin
         bad++; $display("FAIL prio.resp_i got irv=%0b rd=%0h err=%0b drv=%0b derr=%0b exp 1/b/1/0/0", io_instr_rvalid_o, io_instr_rdata_o, io_instr_err_o, io_data_rvalid_o, io_data_err_o); end
      tick();
      clear_inputs();
`ifdef IBEX_ARB_ROUND_ROBIN_EN
      do_reset();
      for (int k = 0; k < 4; k++) begin
         io_instr_req_i = 1'b1; io_data_req_i = 1'b1; io_mem_gnt_i = 1'b1;
         io_mem_rvalid_i = (k > 0);
         settle();
         total++; if (io_data_gnt_o !== (k % 2 == 0) || io_instr_gnt_o !== (k % 2 == 1)) begin
            bad++; $display("FAIL rr.order k=%0d got d=%0b i=%0b", k, io_data_gnt_o, io_instr_gnt_o); end
         tick();
      end
      drain(1);
`endif
   endtask

   task automatic test_hold();
      do_reset();
      io_data_req_i = 1'b1; io_data_addr_i = 32'h400; io_data_be_i = 4'h1;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin io_instr_req_i = 1'b1; io_instr_addr_i = 32'h500; end
         io_mem_gnt_i = (c == 3);
         settle();
         total++; if (io_mem_req_o !== 1'b1 || io_mem_addr_o !== 32'h400) begin bad++; $display("FAIL hold.addr c=%0d got req=%0b addr=%0h exp 1/400", c, io_mem_req_o, io_mem_addr_o); end
         total++; if (io_data_gnt_o !== (c == 3) || io_instr_gnt_o !== 1'b0) begin bad++; $display("FAIL hold.gnt c=%0d got d=%0b i=%0b", c, io_data_gnt_o, io_instr_gnt_o); end
         tick();
      end
      io_data_req_i = 1'b0; io_mem_gnt_i = 1'b1;
      settle();
      total++; if (io_instr_gnt_o !== 1'b1 || io_mem_addr_o !== 32'h500) begin bad++; $display("FAIL hold.after got i=%0b addr=%0h exp 1/500", io_instr_gnt_o, io_mem_addr_o); end
      tick();
      drain(2);
   endtask

   task automatic test_fifo_full();
      do_reset();
      io_instr_req_i = 1'b1; io_instr_addr_i = 32'h40; io_mem_gnt_i = 1'b1;
      tick();
      tick();
      io_mem_rvalid_i = 1'b1; io_mem_rdata_i = 32'h1234;
      settle();
      total++; if (io_outstanding_o !== 3'd2) begin bad++; $display("FAIL full.count got=%0d exp=2", io_outstanding_o); end
      total++; if (io_mem_req_o !== 1'b0 || io_instr_gnt_o !== 1'b0) begin bad++; $display("FAIL full.blocked got req=%0b gnt=%0b exp 0/0", io_mem_req_o, io_instr_gnt_o); end
      total++; if (io_instr_rvalid_o !== 1'b1) begin bad++; $display("FAIL full.resp got=%0b exp=1", io_instr_rvalid_o); end
      tick();
      io_mem_rvalid_i = 1'b0;
      settle();
      total++; if (io_outstanding_o !== 3'd1 || io_mem_req_o !== 1'b1 || io_instr_gnt_o !== 1'b1) begin
         bad++; $display("FAIL full.third got cnt=%0d req=%0b gnt=%0b exp 1/1/1", io_outstanding_o, io_mem_req_o, io_instr_gnt_o); end
      tick();
      drain(2);
      settle();
      total++; if (io_outstanding_o !== 3'd0) begin bad++; $display("FAIL full.drained got=%0d exp=0", io_outstanding_o); end
   endtask

   task automatic test_spurious();
      do_reset();
      io_mem_rvalid_i = 1'b1; io_mem_err_i = 1'b1; io_mem_rdata_i = 32'h77;
      settle();
      total++; if ({io_instr_rvalid_o, io_data_rvalid_o, io_instr_err_o, io_data_err_o} !== 4'b0) begin
         bad++; $display("FAIL spurious.drop got=%04b exp=0000", {io_instr_rvalid_o, io_data_rvalid_o, io_instr_err_o, io_data_err_o}); end
      tick();
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         settle();
         total++; if (io_protocol_err_o !== 1'b1) begin bad++; $display("FAIL spurious.sticky k=%0d got=%0b exp=1", k, io_protocol_err_o); end
         tick();
      end
      do_reset();
      settle();
      total++; if (io_protocol_err_o !== 1'b0) begin bad++; $display("FAIL spurious.cleared got=%0b exp=0", io_protocol_err_o); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      io_instr_req_i = 1'b1; io_data_req_i = 1'b1; io_mem_gnt_i = 1'b1;
      tick();
      tick();
      clear_inputs();
      settle();
      total++; if (io_outstanding_o !== 3'd2) begin bad++; $display("FAIL midflight.pre got=%0d exp=2", io_outstanding_o); end
      reset = 1'b1;
      settle();
      total++; if (io_outstanding_o !== 3'd0 || {io_mem_req_o, io_instr_gnt_o, io_data_gnt_o, io_instr_rvalid_o, io_data_rvalid_o, io_protocol_err_o} !== 6'b0) begin
         bad++; $display("FAIL midflight.reset got cnt=%0d ctrl=%06b exp 0", io_outstanding_o, {io_mem_req_o, io_instr_gnt_o, io_data_gnt_o, io_instr_rvalid_o, io_data_rvalid_o, io_protocol_err_o}); end
      tick();
      reset = 1'b0;
      io_mem_rvalid_i = 1'b1;
      settle();
      total++; if (io_instr_rvalid_o !== 1'b0 || io_data_rvalid_o !== 1'b0) begin bad++; $display("FAIL midflight.late got i=%0b d=%0b exp 0/0", io_instr_rvalid_o, io_data_rvalid_o); end
      tick();
      clear_inputs();
      settle();
      total++; if (io_protocol_err_o !== 1'b1) begin bad++; $display("FAIL midflight.proto_err got=%0b exp=1", io_protocol_err_o); end
   endtask

   task automatic test_random();
      bit          ipend, dpend, held_v, held_id, favour_data, sel, ereq, egnt, rv, head;
      bit          queue_q[$];
      logic [31:0] ia, da, dw, eaddr, ewd;
      logic [3:0]  dbe, ebe;
      logic        dwe, ewe;
      do_reset();
      ipend = 0; dpend = 0; held_v = 0; held_id = 0; favour_data = 1;
      ia = '0; da = '0; dw = '0; dbe = '0; dwe = 1'b0;
      queue_q = {};
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!ipend && $urandom_range(0, 1) == 1) begin ipend = 1; ia = $urandom; end
         if (!dpend && $urandom_range(0, 1) == 1) begin
            dpend = 1; da = $urandom; dw = $urandom; dbe = 4'($urandom); dwe = 1'($urandom);
         end
         io_instr_req_i = ipend; io_instr_addr_i = ia;
         io_data_req_i = dpend; io_data_addr_i = da; io_data_wdata_i = dw; io_data_be_i = dbe; io_data_we_i = dwe;
         io_mem_gnt_i = ($urandom_range(0, 9) < 6);
         rv = (queue_q.size() > 0) && ($urandom_range(0, 1) == 1);
         io_mem_rvalid_i = rv; io_mem_rdata_i = $urandom; io_mem_err_i = 1'($urandom);
         settle();
         // Reference: a waiting request keeps the bus; otherwise the favoured side wins a tie.
         if (held_v) sel = held_id;
         else if (dpend && ipend) sel = favour_data;
         else sel = dpend;
         ereq = (held_v || ipend || dpend) && (queue_q.size() < MAXO);
         egnt = ereq && io_mem_gnt_i;
         eaddr = !ereq ? 32'h0 : (sel ? da : ia);
         ewd   = (ereq && sel) ? dw : 32'h0;
         ebe   = !ereq ? 4'h0 : (sel ? dbe : 4'hF);
         ewe   = ereq && sel && dwe;
         head  = rv ? queue_q[0] : 1'b0;
         total++; if (io_outstanding_o !== 3'(queue_q.size())) begin bad++; $display("FAIL rand.count cyc=%0d got=%0d exp=%0d", cyc, io_outstanding_o, queue_q.size()); end
         total++; if (io_mem_req_o !== ereq) begin bad++; $display("FAIL rand.req cyc=%0d got=%0b exp=%0b", cyc, io_mem_req_o, ereq); end
         total++; if ({io_mem_addr_o, io_mem_wdata_o, io_mem_be_o, io_mem_we_o} !== {eaddr, ewd, ebe, ewe}) begin
            bad++; $display("FAIL rand.mem cyc=%0d got addr=%0h wd=%0h be=%0h we=%0b exp %0h/%0h/%0h/%0b", cyc, io_mem_addr_o, io_mem_wdata_o, io_mem_be_o, io_mem_we_o, eaddr, ewd, ebe, ewe); end
         total++; if (io_data_gnt_o !== (egnt && sel) || io_instr_gnt_o !== (egnt && !sel)) begin
            bad++; $display("FAIL rand.gnt cyc=%0d got d=%0b i=%0b exp d=%0b i=%0b", cyc, io_data_gnt_o, io_instr_gnt_o, egnt && sel, egnt && !sel); end
         total++; if (io_data_rvalid_o !== (rv && head) || io_instr_rvalid_o !== (rv && !head)) begin
            bad++; $display("FAIL rand.rvalid cyc=%0d got d=%0b i=%0b exp d=%0b i=%0b", cyc, io_data_rvalid_o, io_instr_rvalid_o, rv && head, rv && !head); end
         total++; if (io_data_rdata_o !== ((rv && head) ? io_mem_rdata_i : 32'h0) || io_instr_rdata_o !== ((rv && !head) ? io_mem_rdata_i : 32'h0)) begin
            bad++; $display("FAIL rand.rdata cyc=%0d got d=%0h i=%0h", cyc, io_data_rdata_o, io_instr_rdata_o); end
         total++; if (io_data_err_o !== (rv && head && io_mem_err_i) || io_instr_err_o !== (rv && !head && io_mem_err_i)) begin
            bad++; $display("FAIL rand.err cyc=%0d got d=%0b i=%0b", cyc, io_data_err_o, io_instr_err_o); end
         total++; if (io_protocol_err_o !== 1'b0) begin bad++; $display("FAIL rand.proto_err cyc=%0d got=%0b exp=0", cyc, io_protocol_err_o); end
         if (egnt) begin
            queue_q.push_back(sel);
            held_v = 0;
`ifdef IBEX_ARB_ROUND_ROBIN_EN
            favour_data = !sel;
`endif
            if (sel) dpend = 0; else ipend = 0;
         end else if (ereq) begin
            held_v = 1; held_id = sel;
         end
         if (rv) void'(queue_q.pop_front());
         tick();
      end
      drain(queue_q.size());
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_instr_only();
      test_priority();
      test_hold();
      test_fifo_full();
      test_spurious();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ibex_mem_arbiter.md
# ibex_mem_arbiter

Two-to-one memory arbiter between the Ibex core's instruction-fetch port and its load/store port, feeding one shared single-ported memory bus. Both upstream sides and the downstream side use the Ibex req/gnt/rvalid protocol. The block holds the selected request stable until it is granted and tracks outstanding transactions in order. It steers each response back to the requester that issued it. It sits between the core wrapper and the on-chip RAM/interconnect.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: depth of the in-flight ID FIFO. Legal range is 1..4.
- CNT_W, default 3: width of io_outstanding_o. Must be at least clog2(MAX_OUTSTANDING+1).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- io_instr_req_i  in  1 / io_instr_addr_i  in  32  fetch request and word address.
- io_instr_gnt_o  out  1 / io_instr_rvalid_o  out  1 / io_instr_rdata_o  out  32 / io_instr_err_o  out  1  fetch grant and response.
- io_data_req_i  in  1 / io_data_we_i  in  1 / io_data_be_i  in  4 / io_data_addr_i  in  32 / io_data_wdata_i  in  32  load/store request.
- io_data_gnt_o  out  1 / io_data_rvalid_o  out  1 / io_data_rdata_o  out  32 / io_data_err_o  out  1  load/store grant and response.
- io_mem_req_o  out  1 / io_mem_we_o  out  1 / io_mem_be_o  out  4 / io_mem_addr_o  out  32 / io_mem_wdata_o  out  32  downstream request.
- io_mem_gnt_i  in  1 / io_mem_rvalid_i  in  1 / io_mem_rdata_i  in  32 / io_mem_err_i  in  1  downstream grant and response.
- io_outstanding_o  out  CNT_W  number of granted transactions awaiting rvalid.
- io_protocol_err_o  out  1  sticky flag for a spurious rvalid.

## Operation
- **Selection.** In the IDLE state, the block picks a requester from the requests asserted this cycle, using the policy set under Configuration.
  - io_mem_req_o is asserted only when the ID FIFO is not full.
- **Instruction requests downstream.** These drive we=0, be=4'hF and wdata=0. Data requests pass we, be and wdata through unchanged.
- **Hold state.**
  - Transition: if io_mem_req_o=1 and io_mem_gnt_i=0, the FSM enters HOLD and latches the selected ID.
  - While in HOLD: the selection does not change and io_mem_req_o stays high.
  - Exit: HOLD returns to IDLE on io_mem_gnt_i=1.
  - A higher-priority request arriving during HOLD waits.
- **Grant and completion.**
  - Grant: io_*_gnt_o = io_mem_gnt_i AND io_mem_req_o AND (selected ID matches that requester). On a grant, the ID is pushed into the FIFO.
  - Completion: on io_mem_rvalid_i, the head ID is popped. rvalid, rdata and err are routed to that requester.
  - The non-selected requester sees rvalid=0, rdata=0 and err=0.
- **Simultaneous grant and rvalid.** Push and pop happen in the same cycle and the count is unchanged.
  - When the FIFO is full, no grant is issued, even if an rvalid arrives that same cycle.
- **Spurious rvalid.** An io_mem_rvalid_i with the FIFO empty is dropped: neither rvalid_o is asserted. io_protocol_err_o sets and stays set until reset.
- **Reset.** Reset puts the FSM in IDLE, clears the FIFO and count, and clears the sticky error. The round-robin pointer resets to point at instr, which gives data priority first.
  - Reset values: all gnt/rvalid/req outputs are 0, all data outputs are 0, and io_outstanding_o=0.
  - Responses to requests issued before reset arrive as spurious and set io_protocol_err_o.

## Timing
- Request path is combinational and adds zero latency: upstream req/addr to io_mem_req_o/io_mem_addr_o in the same cycle.
- Grant path is combinational: io_mem_gnt_i to io_*_gnt_o in the same cycle.
- Response path is combinational from io_mem_rvalid_i/rdata/err, with steering taken from the registered FIFO head.
- Registered state: FSM (IDLE/HOLD), held ID, round-robin pointer, FIFO (entries, read pointer, write pointer, count), sticky error.
- Back-to-back grants are permitted every cycle while the FIFO has space.
- A request that arrives in the same cycle as its grant is accepted.

## Configuration
- Macro: IBEX_ARB_ROUND_ROBIN_EN.
  - Defined: round-robin arbitration. After each grant, the pointer flips to favour the other requester.
  - Undefined: fixed priority with data over instr. The pointer register is not instantiated.

## Structure
- Shared package ibex_arb_pkg holds:
  - typedef arb_id_e with ARB_INSTR=1'b0 and ARB_DATA=1'b1;
  - constant INSTR_BE=4'hF;
  - the FSM state enum (ARB_IDLE, ARB_HOLD).
- Sub-module ibex_arb_id_fifo: a synchronous FIFO of arb_id_e, MAX_OUTSTANDING deep.
  - Ports: push, pop, head, full, empty, count.
  - Behaviour: simultaneous push and pop are allowed; reset is asynchronous.

## Test plan
- **Instr only.** instr_req=1 with addr 0x100, mem_gnt=1 in the same cycle, rvalid one cycle later with rdata 0xDEADBEEF -> instr_gnt=1 in cycle 0, instr_rvalid=1 with rdata 0xDEADBEEF, data_rvalid=0, mem_we=0, mem_be=0xF.
- **Simultaneous requests, fixed priority.** Both req, mem_gnt=1 -> data granted first and instr granted the next cycle. Responses in order D then I are routed correctly. Under IBEX_ARB_ROUND_ROBIN_EN, a second run of both requests grants in the order D, I, D, I.
- **Hold stability.** data_req with mem_gnt=0 for 3 cycles while instr_req rises in cycle 1 -> mem_addr equals data_addr for all 3 cycles. Data is granted in cycle 3 and instr afterwards.
- **FIFO full.** With MAX_OUTSTANDING=2: two grants and no rvalid -> io_outstanding_o=2, mem_req=0 and no third grant. One rvalid -> count 1 and the third grant is issued the next cycle.
- **Spurious response.** rvalid with an empty FIFO, err=1 -> no upstream rvalid and io_protocol_err_o=1 until reset.
- **Reset mid-flight.** Two outstanding, assert reset for 1 cycle -> count=0 and all outputs 0. The late rvalid sets io_protocol_err_o.
